// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
// FSM states, grant encoding and starvation counter sizing.
package dmem_arb_pkg;

    typedef enum logic {
        ST_NORM  = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_e;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU MEM-stage, DMA and data-memory signals.
// slave = arbiter side, master = surrounding pipeline/memory side.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_valid;
    logic        dma_ready;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rdata, dma_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rdata, dma_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: counts consecutive refused DMA cycles and
// requests a forced DMA slot on the last allowed refusal.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dma_valid,
    input  logic dma_grant,
    output logic force_req
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

    logic [CW-1:0] wait_cnt;

    // Saturating refusal counter, cleared whenever the DMA is served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (dma_grant) begin
            wait_cnt <= '0;
        end else if (dma_valid && wait_cnt != LIM) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_req = dma_valid & ~dma_grant & (wait_cnt == LIM_M1);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between CPU MEM stage and DMA.
// Define DMEM_ARB_STARVE_EN to add the DMA starvation guard (ST_FORCE).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    gnt_e        gnt;
    logic        rd_acc;
    logic        rvalid_q;
    logic [31:0] rdata_q;

`ifdef DMEM_ARB_STARVE_EN
    state_e state;
    state_e state_nxt;
    logic   force_req;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_NORM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a starved DMA earns exactly one forced slot
    always_comb begin
        state_nxt = ST_NORM;
        if (state == ST_NORM && force_req) begin
            state_nxt = ST_FORCE;
        end
    end

    // Grant: forced slot goes to DMA, otherwise CPU has priority
    always_comb begin
        gnt = GNT_NONE;
        if (state == ST_FORCE) begin
            if (bus.dma_valid) begin
                gnt = GNT_DMA;
            end
        end else if (bus.cpu_req) begin
            gnt = GNT_CPU;
        end else if (bus.dma_valid) begin
            gnt = GNT_DMA;
        end
    end

    dmem_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .dma_valid (bus.dma_valid),
        .dma_grant (gnt == GNT_DMA),
        .force_req (force_req)
    );

    assign bus.cpu_stall = bus.cpu_req & (gnt != GNT_CPU) & rst_n;
`else
    logic unused_cfg;
    assign unused_cfg = ^STARVE_LIMIT;

    // Grant: strict CPU priority, DMA only on idle CPU cycles
    always_comb begin
        gnt = GNT_NONE;
        if (bus.cpu_req) begin
            gnt = GNT_CPU;
        end else if (bus.dma_valid) begin
            gnt = GNT_DMA;
        end
    end

    assign bus.cpu_stall = 1'b0;
`endif

    assign bus.dma_ready = (gnt == GNT_DMA) & rst_n;
    assign bus.cpu_rdata = bus.mem_rdata;

    // Memory mux: CPU drives the bus unless the DMA owns the slot
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                bus.mem_we = bus.cpu_we & rst_n;
            end
            GNT_DMA: begin
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                bus.mem_we    = bus.dma_we & rst_n;
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign rd_acc = (gnt == GNT_DMA) & ~bus.dma_we;

    // DMA read return register, one-cycle valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = rdata_q;

endmodule
